// File: rtl/popcount23_vecgen.sv
// Stimulus generator for 23-input popcount cores: builds a vector holding exactly
// k ones, placed by a 16-bit LFSR, and reports the exact count with it.
module popcount23_vecgen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_k,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic [22:0] vec_data,
  output logic [4:0]  vec_k,
  output logic        vec_clamped
);

  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_BUILD  = 2'd1;
  localparam logic [1:0]  ST_HOLD   = 2'd2;
  localparam logic [4:0]  K_MAX     = 5'd23;
  localparam logic [4:0]  IDX_LAST  = 5'd22;

  logic [1:0]  state_reg, state_next;
  logic [15:0] lfsr_reg, lfsr_next;
  logic [4:0]  need_reg, need_next;
  logic [4:0]  idx_reg, idx_next;
  logic [22:0] data_reg, data_next;
  logic [4:0]  k_reg, k_next;
  logic        clamped_reg, clamped_next;

  logic [4:0]  slots;
  logic        set_bit;
  logic        feedback;
  logic        cmd_over;
  logic [4:0]  cmd_kc;
  logic [22:0] build_data;

  assign cmd_over = (cmd_k > K_MAX);
  assign cmd_kc   = cmd_over ? K_MAX : cmd_k;
  assign slots    = K_MAX - idx_reg;
  assign feedback = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  // Once the remaining ones equal the remaining slots every later bit is forced,
  // which guarantees the final popcount equals the requested count.
  assign set_bit  = (need_reg != 5'd0) && ((need_reg == slots) || lfsr_reg[15]);

  genvar gi;
  generate
    for (gi = 0; gi < 23; gi++) begin : g_bit
      assign build_data[gi] = (idx_reg == 5'(gi)) ? set_bit : data_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    lfsr_next    = lfsr_reg;
    need_next    = need_reg;
    idx_next     = idx_reg;
    data_next    = data_reg;
    k_next       = k_reg;
    clamped_next = clamped_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next   = ST_BUILD;
          clamped_next = cmd_over;
          k_next       = cmd_kc;
          need_next    = cmd_kc;
          idx_next     = 5'd0;
          data_next    = '0;
        end
      end
      ST_BUILD: begin
        data_next = build_data;
        need_next = need_reg - {4'b0000, set_bit};
        idx_next  = idx_reg + 5'd1;
        lfsr_next = {lfsr_reg[14:0], feedback};
        if (idx_reg == IDX_LAST) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (vec_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      lfsr_reg    <= LFSR_INIT;
      need_reg    <= 5'd0;
      idx_reg     <= 5'd0;
      data_reg    <= '0;
      k_reg       <= 5'd0;
      clamped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lfsr_reg    <= lfsr_next;
      need_reg    <= need_next;
      idx_reg     <= idx_next;
      data_reg    <= data_next;
      k_reg       <= k_next;
      clamped_reg <= clamped_next;
    end
  end

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign vec_valid   = (state_reg == ST_HOLD);
  assign vec_data    = data_reg;
  assign vec_k       = k_reg;
  assign vec_clamped = clamped_reg;

endmodule

// File: tb/tb_popcount23_vecgen.sv
// Bench for popcount23_vecgen: a driver issues commands and queues the expected
// vectors; a monitor pops and compares each vector the DUT hands over.
module tb_popcount23_vecgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cmd_valid, vec_ready;
  logic [4:0]  cmd_k;
  logic        cmd_ready, vec_valid, vec_clamped;
  logic [22:0] vec_data;
  logic [4:0]  vec_k;

  logic        cmd_valid0, vec_ready0;
  logic [4:0]  cmd_k0;
  logic        cmd_ready0, vec_valid0, vec_clamped0;
  logic [22:0] vec_data0;
  logic [4:0]  vec_k0;

  popcount23_vecgen #(.SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data), .vec_k(vec_k),
    .vec_clamped(vec_clamped)
  );

  popcount23_vecgen #(.SEED(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_k(cmd_k0),
    .vec_valid(vec_valid0), .vec_ready(vec_ready0), .vec_data(vec_data0), .vec_k(vec_k0),
    .vec_clamped(vec_clamped0)
  );

  typedef struct {
    logic [22:0] data;
    logic [4:0]  k;
    logic        clamped;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_lfsr;
  logic [15:0] model_lfsr0;
  logic [22:0] k1_mask = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          accept_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Reference behaviour of one BUILD pass: one decision per slot, LFSR stepping each time.
  function automatic void model(input logic [4:0] k, inout logic [15:0] l,
                                output logic [22:0] d, output logic [4:0] kc, output logic cl);
    int need;
    cl   = (k > 5'd23);
    kc   = cl ? 5'd23 : k;
    need = int'(kc);
    d    = '0;
    for (int i = 0; i < 23; i++) begin
      bit s;
      s = (need != 0) && ((need == 23 - i) || l[15]);
      d[i] = s;
      if (s) need--;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && vec_valid && vec_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_vector");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("vec_data", 32'(vec_data), 32'(e.data));
        check("vec_k", 32'(vec_k), 32'(e.k));
        check("vec_clamped", 32'(vec_clamped), 32'(e.clamped));
        check("popcount_eq_k", $countones(vec_data), 32'(vec_k));
        if (vec_k == 5'd1) k1_mask = k1_mask | vec_data;
        $display("vec k=%0d clamped=%0d data=%06h", vec_k, vec_clamped, vec_data);
      end
    end
  end

  task automatic issue(input logic [4:0] k, input bit push);
    int guard;
    exp_t e;
    cmd_k = k;
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!cmd_ready) fail_now("accept_timeout");
    model(k, model_lfsr, e.data, e.k, e.clamped);
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!vec_valid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!vec_valid) fail_now("valid_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, prev, consume_cyc, guard;
    logic [22:0] hold_data, first_vec, d0;
    logic [4:0]  kc0;
    logic        cl0;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_k = '0; vec_ready = 1'b1;
    cmd_valid0 = 1'b0; cmd_k0 = '0; vec_ready0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_vec_valid", 32'(vec_valid), 0);
    check("rst_vec_data", 32'(vec_data), 0);
    check("rst_vec_k", 32'(vec_k), 0);
    check("rst_vec_clamped", 32'(vec_clamped), 0);
    rst_n = 1'b1;
    model_lfsr = 16'hACE1;
    @(posedge clk);
    #1;

    // Directed corner cases with hand-known results.
    issue(5'd0, 1'b1);
    wait_valid(n);
    check("latency_k0", n, 23);
    check("k0_data", 32'(vec_data), 32'h000000);
    check("k0_k", 32'(vec_k), 0);
    issue(5'd23, 1'b1);
    wait_valid(n);
    check("k23_data", 32'(vec_data), 32'h7FFFFF);
    check("k23_k", 32'(vec_k), 23);
    check("k23_clamped", 32'(vec_clamped), 0);
    issue(5'd30, 1'b1);
    wait_valid(n);
    check("k30_data", 32'(vec_data), 32'h7FFFFF);
    check("k30_k", 32'(vec_k), 23);
    check("k30_clamped", 32'(vec_clamped), 1);

    // Full sweep with vec_ready high: back-to-back issue must be every 25 cycles.
    prev = -1;
    for (int k = 0; k <= 23; k++) begin
      for (int r = 0; r < 50; r++) begin
        issue(5'(k), 1'b1);
        if (prev >= 0) check("issue_interval", accept_cyc - prev, 25);
        prev = accept_cyc;
      end
    end
    wait_valid(n);
    @(posedge clk);
    #1;
    check("k1_multi_position", 32'($countones(k1_mask) > 1), 1);

    // Back-pressure: HOLD must be stable and deaf to commands.
    vec_ready = 1'b0;
    issue(5'd5, 1'b1);
    wait_valid(n);
    hold_data = (exp_q.size() > 0) ? exp_q[0].data : 23'h0;
    for (int i = 0; i < 10; i++) begin
      cmd_k = 5'd9;
      cmd_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
      check("hold_vec_valid", 32'(vec_valid), 1);
      check("hold_cmd_ready", 32'(cmd_ready), 0);
      check("hold_vec_data", 32'(vec_data), 32'(hold_data));
    end
    cmd_k = 5'd3;
    cmd_valid = 1'b1;
    vec_ready = 1'b1;
    @(posedge clk);
    #1;
    consume_cyc = cyc;
    check("release_cmd_ready", 32'(cmd_ready), 1);
    check("release_vec_valid", 32'(vec_valid), 0);
    issue(5'd3, 1'b1);
    check("accept_after_consume", accept_cyc - consume_cyc, 1);
    wait_valid(n);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-build, then the first command must replay identically.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_lfsr = 16'hACE1;
    issue(5'd11, 1'b1);
    first_vec = exp_q[exp_q.size() - 1].data;
    wait_valid(n);
    @(posedge clk);
    #1;
    issue(5'd11, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_cmd_ready", 32'(cmd_ready), 1);
    check("abort_vec_valid", 32'(vec_valid), 0);
    check("abort_vec_data", 32'(vec_data), 0);
    check("abort_vec_k", 32'(vec_k), 0);
    check("abort_vec_clamped", 32'(vec_clamped), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_lfsr = 16'hACE1;
    issue(5'd11, 1'b1);
    wait_valid(n);
    check("replay_after_reset", 32'(vec_data), 32'(first_vec));
    @(posedge clk);
    #1;

    // SEED=0 instance: LFSR must start from 1 and keep running.
    model_lfsr0 = 16'h0001;
    for (int j = 0; j < 2; j++) begin
      model(5'd12, model_lfsr0, d0, kc0, cl0);
      cmd_k0 = 5'd12;
      cmd_valid0 = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid0 = 1'b0;
      guard = 0;
      while (!vec_valid0 && guard < 100) begin
        @(posedge clk);
        #1;
        guard++;
      end
      if (!vec_valid0) fail_now("seed0_valid_timeout");
      check("seed0_popcount", $countones(vec_data0), 12);
      check("seed0_vec_k", 32'(vec_k0), 32'(kc0));
      check("seed0_data", 32'(vec_data0), 32'(d0));
      if (j == 1) check("seed0_not_locked", 32'(vec_data0 != 23'h7FF800), 1);
      $display("vec seed0 k=%0d data=%06h", vec_k0, vec_data0);
      vec_ready0 = 1'b1;
      @(posedge clk);
      #1;
      vec_ready0 = 1'b0;
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
